// File: rtl/seatbelt_warning_ctrl.sv
`default_nettype none
// ============================================================================
// Module : seatbelt_warning_ctrl
// Brief  : Armed-car seatbelt monitor: grace period, bounded pulsed chime, mute.
// Rev    : 1.0  initial release
// ============================================================================
module seatbelt_warning_ctrl #(
  parameter int N_SEATS   = 4,
  parameter int GRACE_CYC = 16,
  parameter int BEEP_ON   = 4,
  parameter int BEEP_OFF  = 4,
  parameter int WARN_CYC  = 64,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Ignition,
  input  logic               DoorClose,
  input  logic [N_SEATS-1:0] Occupied,
  input  logic [N_SEATS-1:0] SeatBelt,
  output logic               Alarm,
  output logic               WarnLamp,
  output logic               Muted,
  output logic [N_SEATS-1:0] SeatStatus
);

  localparam logic [CNT_W-1:0] C_GRACE_LAST = CNT_W'(GRACE_CYC - 1);
  localparam logic [CNT_W-1:0] C_WARN_LAST  = CNT_W'(WARN_CYC - 1);
  localparam logic [CNT_W-1:0] C_PHASE_LAST = CNT_W'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [CNT_W-1:0] C_BEEP_ON    = CNT_W'(BEEP_ON);
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRACE = 2'd1,
    S_BEEP  = 2'd2,
    S_MUTE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_armed;
  logic [N_SEATS-1:0] r_viol;
  logic [N_SEATS-1:0] r_viol_prev;
  logic [N_SEATS-1:0] r_mute_mask;
  logic [CNT_W-1:0]   r_grace_cnt;
  logic [CNT_W-1:0]   r_warn_cnt;
  logic [CNT_W-1:0]   r_phase_cnt;

  logic               w_cond;
  logic               w_new_viol;
  logic               w_unmasked;
  logic [CNT_W-1:0]   w_phase_nxt;

  assign w_cond      = r_armed & (|r_viol);
  assign w_new_viol  = |(r_viol & ~r_viol_prev);
  assign w_unmasked  = |(r_viol & ~r_mute_mask);
  assign w_phase_nxt = (r_phase_cnt == C_PHASE_LAST) ? '0 : r_phase_cnt + C_ONE;

  // Input stage: the FSM only ever sees these registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed     <= 1'b0;
      r_viol      <= '0;
      r_viol_prev <= '0;
      SeatStatus  <= '0;
    end else begin
      r_armed     <= Ignition & DoorClose;
      r_viol      <= Occupied & ~SeatBelt;
      r_viol_prev <= r_viol;
      SeatStatus  <= r_armed ? r_viol : '0;
    end
  end

  // Outputs are assigned alongside each transition so they reflect the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grace_cnt <= '0;
      r_warn_cnt  <= '0;
      r_phase_cnt <= '0;
      r_mute_mask <= '0;
      Alarm       <= 1'b0;
      WarnLamp    <= 1'b0;
      Muted       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cond) begin
            r_state     <= S_GRACE;
            r_grace_cnt <= '0;
            WarnLamp    <= 1'b1;
          end
        end
        S_GRACE: begin
          if (!w_cond) begin
            r_state  <= S_IDLE;
            WarnLamp <= 1'b0;
          end else if (r_grace_cnt == C_GRACE_LAST) begin
            r_state     <= S_BEEP;
            r_warn_cnt  <= '0;
            r_phase_cnt <= '0;
            Alarm       <= 1'b1;
          end else begin
            r_grace_cnt <= r_grace_cnt + C_ONE;
          end
        end
        S_BEEP: begin
          if (!w_cond) begin
            r_state  <= S_IDLE;
            Alarm    <= 1'b0;
            WarnLamp <= 1'b0;
          end else if (w_new_viol) begin
            r_warn_cnt  <= '0;
            r_phase_cnt <= '0;
            Alarm       <= 1'b1;
          end else if (r_warn_cnt == C_WARN_LAST) begin
            r_state     <= S_MUTE;
            r_mute_mask <= r_viol;
            Alarm       <= 1'b0;
            Muted       <= 1'b1;
          end else begin
            r_warn_cnt  <= r_warn_cnt + C_ONE;
            r_phase_cnt <= w_phase_nxt;
            Alarm       <= (w_phase_nxt < C_BEEP_ON);
          end
        end
        S_MUTE: begin
          // Only seats outside the mask captured at mute entry re-arm the chime.
          if (!w_cond) begin
            r_state  <= S_IDLE;
            WarnLamp <= 1'b0;
            Muted    <= 1'b0;
          end else if (w_unmasked) begin
            r_state     <= S_BEEP;
            r_warn_cnt  <= '0;
            r_phase_cnt <= '0;
            Alarm       <= 1'b1;
            Muted       <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          Alarm    <= 1'b0;
          WarnLamp <= 1'b0;
          Muted    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seatbelt_warning_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_seatbelt_warning_ctrl
// Brief  : Directed scoreboard bench for seatbelt_warning_ctrl (default and fast params).
// Rev    : 1.0  initial release
// ============================================================================
module tb_seatbelt_warning_ctrl;

  logic       clk;
  logic       rst_n, ign, door;
  logic [3:0] occ, belt;
  logic       alarm, lamp, muted;
  logic [3:0] status;

  logic       rst6_n, ign6, door6;
  logic [3:0] occ6, belt6;
  logic       alarm6, lamp6, muted6;
  logic [3:0] status6;

  int n_assert;
  int n_fail;

  typedef struct {
    int         run;
    int         cyc;
    bit         sel;
    logic       alarm;
    logic       lamp;
    logic       muted;
    logic [3:0] status;
  } exp_t;

  exp_t sb[$];

  seatbelt_warning_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Ignition(ign), .DoorClose(door),
    .Occupied(occ), .SeatBelt(belt),
    .Alarm(alarm), .WarnLamp(lamp), .Muted(muted), .SeatStatus(status)
  );

  seatbelt_warning_ctrl #(
    .N_SEATS(4), .GRACE_CYC(1), .BEEP_ON(1), .BEEP_OFF(1), .WARN_CYC(5), .CNT_W(16)
  ) dut6 (
    .clk(clk), .rst_n(rst6_n), .Ignition(ign6), .DoorClose(door6),
    .Occupied(occ6), .SeatBelt(belt6),
    .Alarm(alarm6), .WarnLamp(lamp6), .Muted(muted6), .SeatStatus(status6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  // Chime window starting at edge b, length len, period per, first `on` cycles high.
  function automatic logic in_beep(input int n, input int b, input int on,
                                   input int per, input int len);
    return (n >= b) && (n < b + len) && (((n - b) % per) < on);
  endfunction

  task automatic push(input int run, input int n, input logic a, input logic l,
                      input logic m, input logic [3:0] s, input bit sel);
    exp_t x;
    x.run = run; x.cyc = n; x.sel = sel;
    x.alarm = a; x.lamp = l; x.muted = m; x.status = s;
    sb.push_back(x);
  endtask

  task automatic compare_front();
    exp_t       x;
    logic       oa, ol, om;
    logic [3:0] os;
    x  = sb.pop_front();
    oa = x.sel ? alarm6  : alarm;
    ol = x.sel ? lamp6   : lamp;
    om = x.sel ? muted6  : muted;
    os = x.sel ? status6 : status;
    n_assert++;
    assert (oa === x.alarm) else begin
      n_fail++;
      $error("FAIL alarm run=%0d edge=%0d observed=%b expected=%b", x.run, x.cyc, oa, x.alarm);
    end
    n_assert++;
    assert (ol === x.lamp) else begin
      n_fail++;
      $error("FAIL warnlamp run=%0d edge=%0d observed=%b expected=%b", x.run, x.cyc, ol, x.lamp);
    end
    n_assert++;
    assert (om === x.muted) else begin
      n_fail++;
      $error("FAIL muted run=%0d edge=%0d observed=%b expected=%b", x.run, x.cyc, om, x.muted);
    end
    n_assert++;
    assert (os === x.status) else begin
      n_fail++;
      $error("FAIL seatstatus run=%0d edge=%0d observed=%b expected=%b", x.run, x.cyc, os, x.status);
    end
  endtask

  task automatic tick(input int run, input int n, input logic a, input logic l,
                      input logic m, input logic [3:0] s, input bit sel);
    push(run, n, a, l, m, s, sel);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic now_check(input int run, input int n, input logic a, input logic l,
                           input logic m, input logic [3:0] s, input bit sel);
    push(run, n, a, l, m, s, sel);
    #1;
    compare_front();
  endtask

  // Async reset mid-cycle: outputs must clear with no clock edge in between.
  task automatic reset_main(input int run);
    @(negedge clk);
    rst_n = 1'b0;
    now_check(run, 0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] st;
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0; ign = 1'b0; door = 1'b0; occ = 4'b0; belt = 4'b0;
    rst6_n = 1'b0; ign6 = 1'b0; door6 = 1'b0; occ6 = 4'b0; belt6 = 4'b0;

    // Reset state of both instances
    tick(0, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    tick(0, 2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

    // Run 1: driver unbuckled, full chime, mute, new seat re-chimes, masked seat ignored
    ign = 1'b1; door = 1'b1; occ = 4'b0001; belt = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 162; n++) begin
      if (n == 86)  occ  = 4'b0101;
      if (n == 155) belt = 4'b0001;
      if (n == 158) belt = 4'b0000;
      if (n < 2)                    st = 4'b0000;
      else if (n <= 86)             st = 4'b0001;
      else if (n >= 156 && n <= 158) st = 4'b0100;
      else                          st = 4'b0101;
      tick(1, n, in_beep(n, 18, 4, 8, 64) | in_beep(n, 87, 4, 8, 64),
           n >= 2, (n >= 82 && n <= 86) || n >= 151, st, 1'b0);
    end

    // Run 2: driver buckles during grace -> back to idle, no chime
    occ = 4'b0001; belt = 4'b0000;
    reset_main(2);
    for (int n = 1; n <= 30; n++) begin
      if (n == 10) belt = 4'b0001;
      tick(2, n, 1'b0, n >= 2 && n <= 10, 1'b0,
           (n >= 2 && n <= 10) ? 4'b0001 : 4'b0000, 1'b0);
    end

    // Run 3: door opens during an on-phase, closes again -> fresh grace period
    belt = 4'b0000;
    reset_main(3);
    for (int n = 1; n <= 50; n++) begin
      if (n == 20) door = 1'b0;
      if (n == 25) door = 1'b1;
      tick(3, n, (in_beep(n, 18, 4, 8, 64) && n <= 20) | in_beep(n, 42, 4, 8, 64),
           (n >= 2 && n <= 20) || n >= 26, 1'b0,
           ((n >= 2 && n <= 20) || n >= 26) ? 4'b0001 : 4'b0000, 1'b0);
    end

    // Run 4: async reset while chiming, then the same violation replays run-1 timing
    reset_main(4);
    for (int n = 1; n <= 19; n++)
      tick(4, n, in_beep(n, 18, 4, 8, 64), n >= 2, 1'b0,
           (n >= 2) ? 4'b0001 : 4'b0000, 1'b0);
    reset_main(5);
    for (int n = 1; n <= 90; n++)
      tick(5, n, in_beep(n, 18, 4, 8, 64), n >= 2, n >= 82,
           (n >= 2) ? 4'b0001 : 4'b0000, 1'b0);

    // Run 6: fast parameter set on the second instance
    @(negedge clk);
    ign6 = 1'b1; door6 = 1'b1; occ6 = 4'b0001; belt6 = 4'b0000;
    rst6_n = 1'b1;
    for (int n = 1; n <= 12; n++)
      tick(6, n, in_beep(n, 3, 1, 2, 5), n >= 2, n >= 8,
           (n >= 2) ? 4'b0001 : 4'b0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seatbelt_warning_ctrl.md
Name: seatbelt_warning_ctrl

Overview:
Sequential successor to the combinational car-warning gate. Monitors N_SEATS seats and raises a seatbelt warning only while the car is armed (Ignition and DoorClose both high).
- After a programmable grace period, drives a pulsed Alarm chime for a bounded time, then mutes.
- Keeps a steady WarnLamp on and reports which seats are in violation.
- Sits between the body-sensor inputs and the dashboard chime/lamp drivers.

Parameters:
- N_SEATS, 4, number of monitored seats; bit 0 is the driver; legal range ≥1.
- GRACE_CYC, 16, cycles a violation must persist before the chime starts; legal range ≥1.
- BEEP_ON, 4, cycles Alarm is high per chime period; legal range ≥1.
- BEEP_OFF, 4, cycles Alarm is low per chime period; legal range ≥1.
- WARN_CYC, 64, total cycles of chiming before auto-mute; legal range ≥1.
- CNT_W, 16, width of internal counters; must hold max(GRACE_CYC, WARN_CYC, BEEP_ON+BEEP_OFF).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Ignition  input  1  ignition on.
- DoorClose  input  1  all doors closed.
- Occupied  input  N_SEATS  seat occupancy, one bit per seat.
- SeatBelt  input  N_SEATS  belt fastened, one bit per seat.
- Alarm  output  1  pulsed chime drive.
- WarnLamp  output  1  steady warning lamp.
- Muted  output  1  high while in MUTE.
- SeatStatus  output  N_SEATS  registered violation vector.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (async, any time, including mid-chime):
  - state=IDLE; all counters, mute_mask and input registers cleared.
  - Alarm=0, WarnLamp=0, Muted=0, SeatStatus=0 immediately.
- Input stage: each edge registers armed_q = Ignition & DoorClose and viol_q[i] = Occupied[i] & ~SeatBelt[i]. The FSM acts only on these registers.
- cond = armed_q & (|viol_q).
- new_viol = |(viol_q & ~viol_prev), where viol_prev is viol_q delayed one cycle.
- SeatStatus = armed_q ? viol_q : 0, registered; updates 1 edge after the input register.
- All outputs are registered and glitch-free.
- FSM states IDLE, GRACE, BEEP, MUTE. Transitions are evaluated at each edge, and priority is top-down within a state.
  - IDLE: cond -> GRACE, grace_cnt=0.
  - GRACE:
    - !cond -> IDLE.
    - grace_cnt==GRACE_CYC-1 -> BEEP, warn_cnt=0, phase_cnt=0.
    - else grace_cnt++.
  - BEEP:
    - !cond -> IDLE.
    - new_viol -> stay in BEEP; restart warn_cnt=0, phase_cnt=0.
    - warn_cnt==WARN_CYC-1 -> MUTE, mute_mask=viol_q.
    - else warn_cnt++; phase_cnt wraps at BEEP_ON+BEEP_OFF-1.
  - MUTE:
    - !cond -> IDLE.
    - |(viol_q & ~mute_mask) -> BEEP with counters zeroed; no second grace period.
    - A seat clearing and re-violating after entry counts as new only if its bit was not in mute_mask.
- Outputs by state:
  - WarnLamp=1 in GRACE, BEEP and MUTE.
  - Alarm=1 only in BEEP with phase_cnt<BEEP_ON.
  - Muted=1 only in MUTE.
- Latency, with inputs stable before edge 1:
  - viol_q valid at edge 1.
  - GRACE and WarnLamp=1 at edge 2.
  - BEEP and Alarm=1 at edge 2+GRACE_CYC.
  - MUTE at edge 2+GRACE_CYC+WARN_CYC.
- Clear latency: a condition removed before edge k gives IDLE with Alarm=0 and WarnLamp=0 at edge k+1.
- Boundaries:
  - cond drops on the same edge grace_cnt or warn_cnt expires: IDLE wins.
  - WARN_CYC expires mid on-phase: Alarm drops at MUTE entry.
  - WARN_CYC need not be a multiple of BEEP_ON+BEEP_OFF.
  - Ignition toggling restarts from IDLE, including a new grace period.
  - N_SEATS=1 is legal.

Test Plan:
1. Defaults; Ignition=1, DoorClose=1, Occupied=4'b0001, SeatBelt=0 applied before edge 1 -> WarnLamp=1 at edge 2; Alarm=1 at edges 18-21, 0 at 22-25, repeating 8 pulses; Muted=1 at edge 82; SeatStatus=4'b0001 from edge 2.
2. Driver violating, SeatBelt[0]=1 before edge 10 (in GRACE) -> IDLE at edge 11, Alarm never asserted, WarnLamp=0 from edge 11.
3. In MUTE with mask 4'b0001, set Occupied[2]=1, SeatBelt[2]=0 -> BEEP on the next FSM edge, Alarm=1 immediately, chime runs a full 64 cycles; the driver re-buckling and unbuckling alone does not restart the chime.
4. DoorClose=0 during BEEP at an on-phase -> Alarm=0, WarnLamp=0, SeatStatus=0 one edge after the input register; DoorClose=1 again -> a new 16-cycle grace period.
5. rst_n pulled low mid-BEEP (Alarm=1) -> Alarm, WarnLamp, Muted and SeatStatus go 0 without a clock edge; after release with the same violation, the sequence matches scenario 1 timing.
6. Parameters GRACE_CYC=1, BEEP_ON=1, BEEP_OFF=1, WARN_CYC=5 -> Alarm pattern 1,0,1,0,1 starting edge 3; Muted=1 at edge 8; Alarm=0 in MUTE.
